// File: rtl/esp32_cpu_cpu_ocimem_arbiter_pkg.sv
// Shared types and constants for the OCI debug RAM arbiter.
// jdo field positions are fixed by the JTAG debug slave wrapper.
package esp32_CPU_cpu_ocimem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int JDO_W      = 38;

    localparam int RD_BIT   = 35;
    localparam int ADDR_HI  = 17;
    localparam int ADDR_LO  = 10;
    localparam int WDATA_HI = 34;
    localparam int WDATA_LO = 3;

    typedef enum logic [2:0] {
        IDLE,
        J_RD,
        J_RD_CAP,
        J_WR,
        C_RD,
        C_RD_DATA,
        C_WR
    } state_t;

    typedef enum logic {
        REQ_RD,
        REQ_WR
    } jreq_kind_t;

    typedef enum logic {
        GRANT_CPU,
        GRANT_JTAG
    } grant_t;

endpackage

// File: rtl/esp32_cpu_cpu_ocimem_arbiter_if.sv
// Avalon debug_mem slave bundle between the CPU (master) and the arbiter (slave).
// Waitrequest-based backpressure: the master holds its request until waitrequest is low.
interface esp32_cpu_cpu_ocimem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic              avs_debugaccess;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_debugaccess,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_debugaccess,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/esp32_cpu_cpu_ocimem_arbiter_jtag_req.sv
// JTAG strobe decode, one-deep request register, address counter and overrun flag.
// Request visible one cycle after its strobe; never stalls, a newer strobe replaces the pending one.
module esp32_CPU_cpu_ocimem_jtag_req
    import esp32_CPU_cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              served,
    output logic              pend_vld,
    output jreq_kind_t        pend_kind,
    output logic [DATA_W-1:0] pend_dat,
    output logic [ADDR_W-1:0] jaddr,
    output logic              mon_clr,
    output logic              jtag_overrun
);
    logic       new_vld;
    jreq_kind_t new_kind;
    logic       unused_jdo_bits;

    assign unused_jdo_bits = ^{jdo[JDO_W-1:RD_BIT+1], jdo[WDATA_LO-1:0]};

    always_comb begin
        new_vld  = take_action_ocimem_b
                 | (jdo[RD_BIT] & (take_action_ocimem_a | take_no_action_ocimem_a));
        new_kind = take_action_ocimem_b ? REQ_WR : REQ_RD;
        mon_clr  = take_action_ocimem_a | (take_no_action_ocimem_a & jdo[RD_BIT]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_vld     <= 1'b0;
            pend_kind    <= REQ_RD;
            pend_dat     <= '0;
            jaddr        <= '0;
            jtag_overrun <= 1'b0;
        end else begin
            if (new_vld) begin
                pend_vld  <= 1'b1;
                pend_kind <= new_kind;
                pend_dat  <= jdo[WDATA_HI:WDATA_LO];
            end else if (served) begin
                pend_vld <= 1'b0;
            end

            // An explicit address load wins over the post-access increment.
            if (take_action_ocimem_a)
                jaddr <= jdo[ADDR_HI:ADDR_LO];
            else if (served)
                jaddr <= jaddr + ADDR_W'(1);

            if (new_vld && pend_vld && !served)
                jtag_overrun <= 1'b1;
            else if (take_action_ocimem_a)
                jtag_overrun <= 1'b0;
        end
    end
endmodule

// File: rtl/esp32_cpu_cpu_ocimem_arbiter.sv
// Round-robin arbiter of the single-port OCI debug RAM between JTAG actions and the CPU Avalon slave.
// CPU read 2 cycles / write 1 cycle uncontended, at most one JTAG op extra; CPU stalled via avs_waitrequest.
module esp32_cpu_cpu_ocimem_arbiter
    import esp32_CPU_cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [JDO_W-1:0]  jdo,
    esp32_cpu_cpu_ocimem_arbiter_if.slave avs,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun
);
    state_t            state, next_state;
    grant_t            last_grant;
    logic              cpu_req;
    logic              served;
    logic              pend_vld;
    jreq_kind_t        pend_kind;
    logic [DATA_W-1:0] pend_dat;
    logic [ADDR_W-1:0] jaddr;
    logic              mon_clr;

    assign served = (state == J_RD_CAP) || (state == J_WR);

    esp32_CPU_cpu_ocimem_jtag_req #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_jreq (
        .clk                     (clk),
        .reset                   (reset),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .jdo                     (jdo),
        .served                  (served),
        .pend_vld                (pend_vld),
        .pend_kind               (pend_kind),
        .pend_dat                (pend_dat),
        .jaddr                   (jaddr),
        .mon_clr                 (mon_clr),
        .jtag_overrun            (jtag_overrun)
    );

    always_comb begin
        cpu_req    = avs.avs_read | avs.avs_write;
        next_state = state;
        case (state)
            IDLE: begin
                if (pend_vld && (!cpu_req || last_grant == GRANT_CPU))
                    next_state = (pend_kind == REQ_RD) ? J_RD : J_WR;
                else if (cpu_req)
                    next_state = avs.avs_read ? C_RD : C_WR;
            end
            J_RD:      next_state = J_RD_CAP;
            C_RD:      next_state = C_RD_DATA;
            J_RD_CAP,
            J_WR,
            C_RD_DATA,
            C_WR:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        avs.avs_waitrequest = !((state == C_RD_DATA) || (state == C_WR));
        avs.avs_readdata    = (state == C_RD_DATA) ? ram_rdata : '0;
    end

    // RAM port is loaded from next_state so it is registered yet aligned with the state it serves.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= GRANT_CPU;
            ram_addr      <= '0;
            ram_wr        <= 1'b0;
            ram_wdata     <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
        end else begin
            state  <= next_state;
            ram_wr <= 1'b0;

            if (state == IDLE) begin
                if (next_state inside {J_RD, J_WR})
                    last_grant <= GRANT_JTAG;
                else if (next_state inside {C_RD, C_WR})
                    last_grant <= GRANT_CPU;
            end

            case (next_state)
                J_RD: ram_addr <= jaddr;
                J_WR: begin
                    ram_addr  <= jaddr;
                    ram_wr    <= 1'b1;
                    ram_wdata <= pend_dat;
                end
                C_RD: ram_addr <= avs.avs_address;
                C_WR: begin
                    ram_addr  <= avs.avs_address;
                    ram_wr    <= avs.avs_debugaccess;
                    ram_wdata <= avs.avs_writedata;
                end
                default: ;
            endcase

            if (state == J_RD_CAP)
                MonDReg <= ram_rdata;

            if (mon_clr)
                monitor_ready <= 1'b0;
            else if (state == J_RD_CAP)
                monitor_ready <= 1'b1;
        end
    end
endmodule

// File: tb/tb_esp32_cpu_cpu_ocimem_arbiter.sv
// Directed bench for the OCI debug RAM arbiter with a behavioural 256x32 synchronous RAM.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_esp32_cpu_cpu_ocimem_arbiter;
    import esp32_CPU_cpu_ocimem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [37:0] jdo;
    logic [7:0]  ram_addr;
    logic        ram_wr;
    logic [31:0] ram_wdata, ram_rdata, MonDReg;
    logic        monitor_ready, jtag_overrun;

    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [31:0] pre_dat;
    logic [31:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    esp32_cpu_cpu_ocimem_arbiter_if avs_if ();

    esp32_cpu_cpu_ocimem_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .jdo                     (jdo),
        .avs                     (avs_if),
        .ram_addr                (ram_addr),
        .ram_wr                  (ram_wr),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .jtag_overrun            (jtag_overrun)
    );

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_addr] <= pre_dat;
        else if (ram_wr)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    function automatic logic [31:0] init_val(logic [7:0] a);
        return (a == 8'h10) ? 32'hDEAD_BEEF : {24'hA0_0000, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_a(input logic rd, input logic [7:0] a);
        logic [37:0] j;
        j = '0;
        j[35] = rd;
        j[17:10] = a;
        jdo = j;
        take_action_ocimem_a = 1'b1;
        tick;
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_no_a(input logic rd);
        logic [37:0] j;
        j = '0;
        j[35] = rd;
        jdo = j;
        take_no_action_ocimem_a = 1'b1;
        tick;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        jdo = j;
        take_action_ocimem_b = 1'b1;
        tick;
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int lat);
        avs_if.avs_address = a;
        avs_if.avs_read    = 1'b1;
        lat = 0;
        while (avs_if.avs_waitrequest && lat < 20) begin
            tick;
            lat++;
        end
        chk("cpu_rd_wait_done", 32'(avs_if.avs_waitrequest), 32'd0);
        d = avs_if.avs_readdata;
        tick;
        avs_if.avs_read = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic dbg, output int lat);
        avs_if.avs_address     = a;
        avs_if.avs_writedata   = d;
        avs_if.avs_debugaccess = dbg;
        avs_if.avs_write       = 1'b1;
        lat = 0;
        while (avs_if.avs_waitrequest && lat < 20) begin
            tick;
            lat++;
        end
        chk("cpu_wr_wait_done", 32'(avs_if.avs_waitrequest), 32'd0);
        tick;
        avs_if.avs_write = 1'b0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_waitreq"},  32'(avs_if.avs_waitrequest), 32'd1);
        chk({pfx, "_readdata"}, avs_if.avs_readdata,         32'd0);
        chk({pfx, "_ram_wr"},   32'(ram_wr),                 32'd0);
        chk({pfx, "_ram_addr"}, 32'(ram_addr),               32'd0);
        chk({pfx, "_ram_wdat"}, ram_wdata,                   32'd0);
        chk({pfx, "_mondreg"},  MonDReg,                     32'd0);
        chk({pfx, "_mon_rdy"},  32'(monitor_ready),          32'd0);
        chk({pfx, "_overrun"},  32'(jtag_overrun),           32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          lat;

        reset = 1'b1;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        jdo = '0;
        avs_if.avs_address = '0;
        avs_if.avs_read = 1'b0;
        avs_if.avs_write = 1'b0;
        avs_if.avs_writedata = '0;
        avs_if.avs_debugaccess = 1'b0;
        pre_en = 1'b0;
        pre_addr = '0;
        pre_dat = '0;
        tick;
        for (int i = 0; i < 256; i++) begin
            pre_en   = 1'b1;
            pre_addr = i[7:0];
            pre_dat  = init_val(i[7:0]);
            tick;
        end
        pre_en = 1'b0;
        tick;
        chk_reset_vals("rst");
        reset = 1'b0;
        tick;

        // Contention straight after reset: JTAG wins the first tie.
        strobe_a(1'b1, 8'h40);
        cpu_read(8'h20, d, lat);
        chk("cont_lat", 32'(lat), 32'd5);
        chk("cont_data", d, 32'hA000_0020);
        chk("cont_jtag_first", MonDReg, 32'hA000_0040);
        chk("cont_mon_rdy", 32'(monitor_ready), 32'd1);

        // Address load and read: monitor_ready rises exactly at cycle 4.
        strobe_a(1'b1, 8'h10);
        chk("ld_mon_clr_c1", 32'(monitor_ready), 32'd0);
        repeat (2) tick;
        chk("ld_mon_rdy_c3", 32'(monitor_ready), 32'd0);
        tick;
        chk("ld_mon_rdy_c4", 32'(monitor_ready), 32'd1);
        chk("ld_mondreg", MonDReg, 32'hDEAD_BEEF);

        // Address advanced to 0x11 after the read.
        strobe_no_a(1'b1);
        chk("noa_mon_clr", 32'(monitor_ready), 32'd0);
        repeat (3) tick;
        chk("noa_mondreg", MonDReg, 32'hA000_0011);
        strobe_no_a(1'b0);
        repeat (3) tick;
        chk("noa_norrd_mon", 32'(monitor_ready), 32'd1);

        // Writes wrapping 0xFF -> 0x00.
        strobe_a(1'b0, 8'hFF);
        strobe_b(32'h1);
        repeat (3) tick;
        strobe_b(32'h2);
        repeat (4) tick;
        chk("wrap_ff", mem[8'hFF], 32'h1);
        chk("wrap_00", mem[8'h00], 32'h2);
        chk("wrap_no_ovr", 32'(jtag_overrun), 32'd0);

        // Debugaccess gating.
        cpu_write(8'h30, 32'h55, 1'b0, lat);
        chk("dbg0_lat", 32'(lat), 32'd1);
        chk("dbg0_mem", mem[8'h30], 32'hA000_0030);
        cpu_write(8'h30, 32'h55, 1'b1, lat);
        chk("dbg1_lat", 32'(lat), 32'd1);
        chk("dbg1_mem", mem[8'h30], 32'h55);

        // Round-robin between continuous CPU reads and periodic JTAG writes.
        strobe_a(1'b0, 8'h80);
        fork
            begin
                logic [31:0] rd;
                int          rl;
                for (int i = 0; i < 8; i++) begin
                    cpu_read(8'(8'h60 + i), rd, rl);
                    chk("rr_data", rd, {24'hA0_0000, 8'(8'h60 + i)});
                    chk("rr_wait_le4", 32'(rl <= 4), 32'd1);
                end
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    strobe_b(32'hB0 + k);
                    repeat (4) tick;
                end
            end
        join
        repeat (3) tick;
        for (int k = 0; k < 4; k++)
            chk("rr_jwr_mem", mem[8'(8'h80 + k)], 32'hB0 + k);
        chk("rr_no_ovr", 32'(jtag_overrun), 32'd0);

        // Overrun: second write strobe replaces the still-pending first one.
        strobe_a(1'b0, 8'h50);
        fork
            begin
                logic [31:0] rd;
                int          rl;
                cpu_read(8'h21, rd, rl);
                chk("ovr_cpu_data", rd, 32'hA000_0021);
            end
            begin
                strobe_b(32'h111);
                strobe_b(32'h222);
            end
        join
        repeat (3) tick;
        chk("ovr_flag", 32'(jtag_overrun), 32'd1);
        chk("ovr_mem50", mem[8'h50], 32'h222);
        chk("ovr_mem51", mem[8'h51], 32'hA000_0051);

        // Reset while in C_RD.
        avs_if.avs_address = 8'h22;
        avs_if.avs_read    = 1'b1;
        tick;
        chk("crd_waitreq", 32'(avs_if.avs_waitrequest), 32'd1);
        chk("crd_ram_addr", 32'(ram_addr), 32'h22);
        reset = 1'b1;
        tick;
        avs_if.avs_read = 1'b0;
        chk_reset_vals("midrst");
        reset = 1'b0;
        tick;

        // Recovery: uncontended read of the aborted address.
        cpu_read(8'h22, d, lat);
        chk("post_lat", 32'(lat), 32'd2);
        chk("post_data", d, 32'hA000_0022);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
